// File: rtl/xyz_debug_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between JTAG monitor commands and the CPU Avalon debug port.
// Build option: define XYZ_OCIMEM_JTAG_PRIORITY_EN to make JTAG win every conflict instead of round-robin.
module xyz_debug_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [37:0]       jdo,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {IDLE, CPU_RD, J_RD} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] jaddr;
  logic              jpend;
  logic              jwrite;
  logic [DATA_W-1:0] jwdata;
  logic              cpu_req;
  logic              grant_cpu;
  logic              grant_jtag;
  logic              j_done;
  logic              j_busy;
  logic              unused_jdo;

  assign unused_jdo    = ^{jdo[37:36], jdo[32]};
  assign monitor_ready = ~jpend;
  assign cpu_req       = cpu_read | cpu_write;

`ifdef XYZ_OCIMEM_JTAG_PRIORITY_EN
  always_comb begin
    grant_cpu  = 1'b0;
    grant_jtag = 1'b0;
    if (!reset && state == IDLE) begin
      grant_jtag = jpend;
      grant_cpu  = cpu_req & ~jpend;
    end
  end
`else
  // last = 1 means JTAG had the most recent grant; the other side wins a tie
  logic last;

  always_comb begin
    grant_cpu  = 1'b0;
    grant_jtag = 1'b0;
    if (!reset && state == IDLE) begin
      if (jpend && cpu_req) begin
        grant_jtag = ~last;
        grant_cpu  = last;
      end else begin
        grant_jtag = jpend;
        grant_cpu  = cpu_req;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           last <= 1'b0;
    else if (grant_jtag) last <= 1'b1;
    else if (grant_cpu)  last <= 1'b0;
  end
`endif

  always_comb begin
    state_nxt       = state;
    ram_addr        = '0;
    ram_we          = 1'b0;
    ram_wdata       = '0;
    cpu_waitrequest = 1'b1;
    cpu_readdata    = '0;
    case (state)
      IDLE: begin
        if (grant_jtag) begin
          ram_addr = jaddr;
          if (jwrite) begin
            ram_we    = 1'b1;
            ram_wdata = jwdata;
          end else begin
            state_nxt = J_RD;
          end
        end else if (grant_cpu) begin
          ram_addr = cpu_address;
          if (cpu_write) begin
            ram_we          = 1'b1;
            ram_wdata       = cpu_writedata;
            cpu_waitrequest = 1'b0;
          end else begin
            state_nxt = CPU_RD;
          end
        end
      end
      CPU_RD: begin
        cpu_readdata    = ram_rdata;
        cpu_waitrequest = 1'b0;
        state_nxt       = IDLE;
      end
      J_RD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A strobe landing on the completion cycle is accepted since jpend drops on that same edge
  assign j_done = (grant_jtag & jwrite) | (state == J_RD);
  assign j_busy = jpend & ~j_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jaddr         <= '0;
      jpend         <= 1'b0;
      jwrite        <= 1'b0;
      jwdata        <= '0;
      MonDReg       <= '0;
      monitor_error <= 1'b0;
    end else begin
      if (state == J_RD) MonDReg <= ram_rdata;
      if (j_done) begin
        jpend <= 1'b0;
        jaddr <= jaddr + 1'b1;
      end
      if (take_action_ocimem_a) begin
        if (j_busy) begin
          monitor_error <= 1'b1;
        end else begin
          jaddr <= jdo[ADDR_W-1:0];
          if (jdo[33]) monitor_error <= 1'b0;
          if (jdo[35]) begin
            jpend  <= 1'b1;
            jwrite <= 1'b0;
          end
        end
      end else if (take_action_ocimem_b) begin
        if (j_busy) begin
          monitor_error <= 1'b1;
        end else begin
          jpend  <= 1'b1;
          jwrite <= jdo[34];
          jwdata <= jdo[DATA_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_xyz_debug_ocimem_arbiter.sv
// Directed bench for xyz_debug_ocimem_arbiter with a RAM model and a scoreboard of expected RAM writes.
module tb_xyz_debug_ocimem_arbiter;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        take_a, take_b;
  logic [37:0] jdo;
  logic [7:0]  cpu_address;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_writedata;
  logic [31:0] cpu_readdata;
  logic        cpu_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;

  logic [31:0] mem [256];
  wr_t         exp_q [$];
  int          checks = 0;
  int          passed = 0;
  bit          accepted;

  xyz_debug_ocimem_arbiter dut (
    .clk                  (clk),
    .reset                (reset),
    .take_action_ocimem_a (take_a),
    .take_action_ocimem_b (take_b),
    .jdo                  (jdo),
    .cpu_address          (cpu_address),
    .cpu_read             (cpu_read),
    .cpu_write            (cpu_write),
    .cpu_writedata        (cpu_writedata),
    .cpu_readdata         (cpu_readdata),
    .cpu_waitrequest      (cpu_waitrequest),
    .ram_addr             (ram_addr),
    .ram_we               (ram_we),
    .ram_wdata            (ram_wdata),
    .ram_rdata            (ram_rdata),
    .MonDReg              (MonDReg),
    .monitor_ready        (monitor_ready),
    .monitor_error        (monitor_error)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data for an address appears the cycle after it is presented
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  function automatic logic [37:0] jdoA(input logic [7:0] a, input bit rd, input bit clr);
    logic [37:0] j;
    j      = '0;
    j[7:0] = a;
    j[35]  = rd;
    j[33]  = clr;
    return j;
  endfunction

  function automatic logic [37:0] jdoB(input bit wr, input logic [31:0] d);
    logic [37:0] j;
    j       = '0;
    j[31:0] = d;
    j[34]   = wr;
    return j;
  endfunction

  task automatic applyStimulus(input bit a, input bit b, input logic [37:0] j);
    take_a = a;
    take_b = b;
    jdo    = j;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) begin
      passed++;
    end else begin
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkWrite(input string tag);
    wr_t e;
    checkOutput({tag, "_we"}, 32'(ram_we), 32'd1);
    if (exp_q.size() == 0) begin
      checks++;
      $error("[TB] FAIL %s_sb: observed=write expected=empty-queue", tag);
    end else begin
      e = exp_q.pop_front();
      checkOutput({tag, "_addr"}, 32'(ram_addr), 32'(e.addr));
      checkOutput({tag, "_data"}, ram_wdata, e.data);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[255] = 32'h1234_5678;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, '0);
    cpu_address = 8'h33; cpu_read = 1'b0; cpu_write = 1'b1; cpu_writedata = 32'hBAD0_BAD0;

    // Reset state, with a CPU write held to prove it is stalled
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_ready", 32'(monitor_ready), 32'd1);
    checkOutput("rst_error", 32'(monitor_error), 32'd0);
    checkOutput("rst_mondreg", MonDReg, 32'd0);
    checkOutput("rst_waitreq", 32'(cpu_waitrequest), 32'd1);
    checkOutput("rst_ram_we", 32'(ram_we), 32'd0);
    checkOutput("rst_ram_addr", 32'(ram_addr), 32'd0);
    checkOutput("rst_ram_wdata", ram_wdata, 32'd0);
    checkOutput("rst_readdata", cpu_readdata, 32'd0);
    @(negedge clk); reset = 1'b0; cpu_write = 1'b0;

    // JTAG write 0xDEADBEEF to 0x10
    @(negedge clk); applyStimulus(1'b1, 1'b0, jdoA(8'h10, 1'b0, 1'b0));
    @(negedge clk); applyStimulus(1'b0, 1'b1, jdoB(1'b1, 32'hDEAD_BEEF));
    exp_q.push_back('{8'h10, 32'hDEAD_BEEF});
    #1 checkOutput("addr_only_ready", 32'(monitor_ready), 32'd1);
    @(negedge clk); applyStimulus(1'b0, 1'b0, '0);
    #1 checkOutput("jwr_ready_low", 32'(monitor_ready), 32'd0);
    checkWrite("jwr_10");
    @(negedge clk); #1;
    checkOutput("jwr_ready_high", 32'(monitor_ready), 32'd1);
    checkOutput("jwr_we_off", 32'(ram_we), 32'd0);

    // Auto-increment: next data strobe lands at 0x11
    @(negedge clk); applyStimulus(1'b0, 1'b1, jdoB(1'b1, 32'hA5A5_0011));
    exp_q.push_back('{8'h11, 32'hA5A5_0011});
    @(negedge clk); applyStimulus(1'b0, 1'b0, '0);
    #1 checkWrite("jaddr_inc");

    // JTAG read of 0xFF via address strobe, then wrap to 0x00
    @(negedge clk); applyStimulus(1'b1, 1'b0, jdoA(8'hFF, 1'b1, 1'b0));
    @(negedge clk); applyStimulus(1'b0, 1'b0, '0);
    #1 checkOutput("jrd_ram_addr", 32'(ram_addr), 32'h0000_00FF);
    checkOutput("jrd_ready_low", 32'(monitor_ready), 32'd0);
    @(negedge clk); #1 checkOutput("jrd_mondreg_early", MonDReg, 32'd0);
    @(negedge clk); #1 checkOutput("jrd_mondreg", MonDReg, 32'h1234_5678);
    checkOutput("jrd_ready_high", 32'(monitor_ready), 32'd1);
    @(negedge clk); applyStimulus(1'b0, 1'b1, jdoB(1'b0, 32'd0));
    @(negedge clk); applyStimulus(1'b0, 1'b0, '0);
    #1 checkOutput("wrap_ram_addr", 32'(ram_addr), 32'd0);
    checkOutput("wrap_ram_we", 32'(ram_we), 32'd0);
    @(negedge clk);
    @(negedge clk); #1 checkOutput("wrap_mondreg", MonDReg, 32'hC0DE_0000);

    // CPU read of 0x10: one wait state
    @(negedge clk); cpu_address = 8'h10; cpu_read = 1'b1;
    #1 checkOutput("cpurd_wait0", 32'(cpu_waitrequest), 32'd1);
    checkOutput("cpurd_ram_addr", 32'(ram_addr), 32'h10);
    @(negedge clk); #1 checkOutput("cpurd_wait1", 32'(cpu_waitrequest), 32'd0);
    checkOutput("cpurd_data", cpu_readdata, 32'hDEAD_BEEF);
    @(negedge clk); cpu_read = 1'b0;

    // Conflicting writes twice; last grant was CPU so JTAG goes first each time
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); applyStimulus(1'b0, 1'b1, jdoB(1'b1, 32'h1111_0000 + 32'(i)));
      exp_q.push_back('{8'(1 + i), 32'h1111_0000 + 32'(i)});
      exp_q.push_back('{8'(8'h20 + i), 32'h2222_0000 + 32'(i)});
      @(negedge clk); applyStimulus(1'b0, 1'b0, '0);
      cpu_write = 1'b1; cpu_address = 8'(8'h20 + i); cpu_writedata = 32'h2222_0000 + 32'(i);
      #1 checkWrite($sformatf("conflict%0d_jtag", i));
      checkOutput($sformatf("conflict%0d_cpu_wait", i), 32'(cpu_waitrequest), 32'd1);
      @(negedge clk); #1 checkWrite($sformatf("conflict%0d_cpu", i));
      checkOutput($sformatf("conflict%0d_cpu_go", i), 32'(cpu_waitrequest), 32'd0);
      @(negedge clk); cpu_write = 1'b0;
    end

    // JTAG wins alone, then a back-to-back strobe on its completion cycle meets a CPU write
    @(negedge clk); applyStimulus(1'b0, 1'b1, jdoB(1'b1, 32'h3333_0003));
    exp_q.push_back('{8'h03, 32'h3333_0003});
    @(negedge clk); applyStimulus(1'b0, 1'b1, jdoB(1'b1, 32'h4444_0004));
    #1 checkWrite("b2b_first");
`ifdef XYZ_OCIMEM_JTAG_PRIORITY_EN
    exp_q.push_back('{8'h04, 32'h4444_0004});
    exp_q.push_back('{8'h24, 32'h5555_0024});
`else
    exp_q.push_back('{8'h24, 32'h5555_0024});
    exp_q.push_back('{8'h04, 32'h4444_0004});
`endif
    @(negedge clk); applyStimulus(1'b0, 1'b0, '0);
    cpu_write = 1'b1; cpu_address = 8'h24; cpu_writedata = 32'h5555_0024;
    #1 checkOutput("b2b_no_error", 32'(monitor_error), 32'd0);
    for (int k = 0; k < 2; k++) begin
      if (k > 0) begin
        @(negedge clk);
        if (accepted) cpu_write = 1'b0;
        #1;
      end
      checkWrite($sformatf("b2b_turn%0d", k));
      accepted = cpu_write && !cpu_waitrequest;
    end
    @(negedge clk); cpu_write = 1'b0;

    // Overrun: JTAG read queued behind a CPU read, second strobe dropped
    @(negedge clk); cpu_address = 8'h10; cpu_read = 1'b1;
    applyStimulus(1'b0, 1'b1, jdoB(1'b0, 32'd0));
    #1 checkOutput("ovr_cpu_wait", 32'(cpu_waitrequest), 32'd1);
    @(negedge clk); applyStimulus(1'b0, 1'b1, jdoB(1'b0, 32'd0));
    #1 checkOutput("ovr_cpu_data", cpu_readdata, 32'hDEAD_BEEF);
    checkOutput("ovr_error_pre", 32'(monitor_error), 32'd0);
    @(negedge clk); applyStimulus(1'b0, 1'b0, '0); cpu_read = 1'b0;
    #1 checkOutput("ovr_error_set", 32'(monitor_error), 32'd1);
    checkOutput("ovr_jrd_addr", 32'(ram_addr), 32'h05);
    @(negedge clk);
    @(negedge clk); #1 checkOutput("ovr_mondreg", MonDReg, 32'hC0DE_0005);
    checkOutput("ovr_ready", 32'(monitor_ready), 32'd1);
    checkOutput("ovr_error_sticky", 32'(monitor_error), 32'd1);
    @(negedge clk); applyStimulus(1'b1, 1'b0, jdoA(8'h30, 1'b0, 1'b1));
    @(negedge clk); applyStimulus(1'b0, 1'b0, '0);
    #1 checkOutput("ovr_error_clear", 32'(monitor_error), 32'd0);
    checkOutput("ovr_dropped", 32'(monitor_ready), 32'd1);

    // Reset while in J_RD
    @(negedge clk); applyStimulus(1'b1, 1'b0, jdoA(8'h40, 1'b1, 1'b0));
    @(negedge clk); applyStimulus(1'b0, 1'b0, '0);
    #1 checkOutput("rstrd_ram_addr", 32'(ram_addr), 32'h40);
    @(negedge clk); reset = 1'b1; cpu_write = 1'b1;
    #1 checkOutput("rstrd_mondreg", MonDReg, 32'd0);
    checkOutput("rstrd_ready", 32'(monitor_ready), 32'd1);
    checkOutput("rstrd_waitreq", 32'(cpu_waitrequest), 32'd1);
    checkOutput("rstrd_ram_we", 32'(ram_we), 32'd0);
    @(negedge clk); #1 checkOutput("rstrd_mondreg_hold", MonDReg, 32'd0);
    @(negedge clk); reset = 1'b0; cpu_write = 1'b0;
    @(negedge clk); applyStimulus(1'b0, 1'b1, jdoB(1'b1, 32'h6666_6666));
    exp_q.push_back('{8'h00, 32'h6666_6666});
    @(negedge clk); applyStimulus(1'b0, 1'b0, '0);
    #1 checkWrite("rstrd_jaddr0");

    @(negedge clk);
    checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/xyz_debug_ocimem_arbiter.md
# xyz_debug_ocimem_arbiter

Arbitrates a single-port on-chip debug memory between the JTAG debug-slave command path and the CPU's Avalon debug data port. JTAG commands arrive as one-cycle `take_action_ocimem_*` strobes with a 38-bit `jdo` payload, already synchronised into `clk`. The block sequences each access, returns read data in `MonDReg` and reports completion and overrun status on `monitor_ready` and `monitor_error`. It sits between the debug-slave wrapper's sysclk outputs and the OCI RAM instance inside the CPU debug module.

## Interface
Parameters:
- ADDR_W, 8, word-address width of the debug RAM
- DATA_W, 32, data width; fixed at 32 for `MonDReg` compatibility

Ports:
- clk  in  1  system clock; all logic is in this domain
- reset  in  1  asynchronous, active-high reset
- take_action_ocimem_a  in  1  JTAG address/control strobe, one cycle
- take_action_ocimem_b  in  1  JTAG data-access strobe, one cycle
- jdo  in  38  JTAG payload, sampled on either strobe
- cpu_address  in  ADDR_W  CPU word address
- cpu_read  in  1  CPU read request, held until accepted
- cpu_write  in  1  CPU write request, held until accepted
- cpu_writedata  in  32  CPU write data
- cpu_readdata  out  32  CPU read data, valid when `cpu_read` is high and `cpu_waitrequest` is low
- cpu_waitrequest  out  1  Avalon stall
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid one cycle after `ram_addr`
- MonDReg  out  32  last JTAG read data
- monitor_ready  out  1  JTAG access complete, no access pending
- monitor_error  out  1  sticky overrun flag

## Operation

**JTAG address strobe (`take_action_ocimem_a`)**
- Loads `jaddr <= jdo[ADDR_W-1:0]`.
- `jdo[33]=1` clears `monitor_error`.
- `jdo[35]=1` also queues a read at the new address.

**JTAG data strobe (`take_action_ocimem_b`)**
- Queues an access at `jaddr`.
- `jdo[34]=1` selects a write of `jdo[31:0]`; `jdo[34]=0` selects a read.

**Queueing and overrun**
- A queued request sets `jpend` and clears `monitor_ready`.
- A strobe arriving while `jpend` is set is dropped and sets `monitor_error`. An address strobe in that case does not change `jaddr`.

**Auto-increment**
- After every completed JTAG access, `jaddr <= jaddr+1`, modulo 2^ADDR_W.
- The address wraps from all-ones to 0 with no error.

**FSM states**
- IDLE
- CPU_RD
- J_RD

**Transitions**
- IDLE, grant to CPU write: `ram_we=1` and `cpu_waitrequest=0` in the same cycle; stay in IDLE.
- IDLE, grant to CPU read: drive `ram_addr=cpu_address`; go to CPU_RD.
- CPU_RD: `cpu_readdata=ram_rdata`, `cpu_waitrequest=0`; go to IDLE.
- IDLE, grant to JTAG write: `ram_we=1`; clear `jpend`, set `monitor_ready`, increment `jaddr`; stay in IDLE.
- IDLE, grant to JTAG read: drive `ram_addr=jaddr`; go to J_RD.
- J_RD: `MonDReg<=ram_rdata`; clear `jpend`, set `monitor_ready`, increment `jaddr`; go to IDLE.

**Grants**
- Issued only in IDLE.
- Only one access is in flight at a time; the RAM never sees two accesses in one cycle.
- `cpu_read` and `cpu_write` both high: treat as a write.

**Arbitration (default)**
- Round-robin when both sides request in the same IDLE cycle.
- `last` is set to the side granted, on every grant, conflicting or not.
- On conflict the side that is not `last` wins. After reset `last` = CPU, so JTAG wins the first conflict.

## Timing
- CPU write: 0 wait states.
- CPU read: 1 wait state; data is returned in the 2nd cycle.
- JTAG write: `monitor_ready` rises 1 cycle after the strobe if uncontested.
- JTAG read: `MonDReg` updates and `monitor_ready` rises 2 cycles after the strobe if uncontested.
- A losing requester waits at most one CPU or JTAG transaction, i.e. 2 cycles.
- `cpu_waitrequest` is combinational. It is 1 whenever the CPU is not granted or not completing, including during reset.
- Reset values:
  - state = IDLE, `jaddr`=0, `jpend`=0, `last`=CPU
  - `MonDReg`=0, `monitor_ready`=1, `monitor_error`=0
  - `cpu_readdata`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0
- Reset asserted mid-read discards the access. No `MonDReg` update and no `jaddr` increment occur.
- A strobe coinciding with the completion cycle of the previous JTAG access is accepted, not flagged, because `jpend` clears the same edge.

## Configuration
- `XYZ_OCIMEM_JTAG_PRIORITY_EN` defined: fixed priority. JTAG wins every conflict and `last` is not implemented.
- Undefined: round-robin as described in Operation.

## Test plan
- After reset, `jdo[7:0]`=0x10 with `jdo[35]=0` via strobe a, then strobe b with `jdo[34]=1`, `jdo[31:0]`=0xDEADBEEF.
  - Required: RAM[0x10]=0xDEADBEEF.
  - Required: `monitor_ready` low 1 cycle, then high.
  - Required: `jaddr`=0x11.
- Strobe a with `jdo[7:0]`=0xFF, `jdo[35]=1`, RAM[0xFF]=0x12345678.
  - Required: 2 cycles later `MonDReg`=0x12345678.
  - Required: `jaddr` wraps to 0x00.
- CPU read of address 0x10 held high.
  - Required: `cpu_waitrequest` high cycle 0, low cycle 1.
  - Required: `cpu_readdata`=0xDEADBEEF.
- CPU write and JTAG write in the same cycle, repeated twice.
  - Default: JTAG, CPU, JTAG, CPU grant order.
  - `XYZ_OCIMEM_JTAG_PRIORITY_EN`: JTAG always granted first.
- While a JTAG read is stalled behind a CPU read, issue a second strobe b.
  - Required: `monitor_error`=1 and the strobe is dropped.
  - Required: strobe a with `jdo[33]=1` clears the error.
- Assert `reset` in J_RD.
  - Required: `MonDReg` stays 0, `monitor_ready`=1, `jaddr`=0, `cpu_waitrequest`=1.
